// File: rtl/va_sweep_sequencer.sv
// va_sweep_sequencer: Avalon-MM sweep controller for the VA generator.
// Steps the control word over N points, settles, then handshakes a capture.
module va_sweep_sequencer #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int SETTLE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] gen_word,
  output logic              meas_start,
  input  logic              meas_done,
  output logic              irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_STEP,
    S_FINISH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0]   start_word;
  logic [DATA_W-1:0]   step_word;
  logic [CNT_W-1:0]    num_points;
  logic [SETTLE_W-1:0] settle;

  logic [DATA_W-1:0]   gen_word_nxt;
  logic [CNT_W-1:0]    idx;
  logic [CNT_W-1:0]    idx_nxt;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] cnt_nxt;
  logic                done;
  logic                done_nxt;
  logic                mstart_nxt;

  logic                wr_en;
  logic                ctrl_wr;
  logic                start_req;
  logic                abort_req;
  logic                done_clr;
  logic                busy;
  logic                last_point;
  logic [DATA_W-1:0]   status;

  assign wr_en      = chipselect & ~write_n;
  assign ctrl_wr    = wr_en & (address == 3'd0);
  assign abort_req  = ctrl_wr & writedata[1];
  assign start_req  = ctrl_wr & writedata[0] & ~writedata[1];
  assign done_clr   = wr_en & (address == 3'd5) & writedata[1];
  assign busy       = (state != S_IDLE);
  assign last_point = (idx == num_points - CNT_W'(1));
  assign irq        = done;

  // Configuration registers; frozen while a sweep runs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_word <= '0;
      step_word  <= '0;
      num_points <= '0;
      settle     <= '0;
    end else if (wr_en && !busy) begin
      case (address)
        3'd1:    start_word <= writedata;
        3'd2:    step_word  <= writedata;
        3'd3:    num_points <= writedata[CNT_W-1:0];
        3'd4:    settle     <= writedata[SETTLE_W-1:0];
        default: ;
      endcase
    end
  end

  // Sweep state and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      gen_word   <= '0;
      idx        <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      meas_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      gen_word   <= gen_word_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      done       <= done_nxt;
      meas_start <= mstart_nxt;
    end
  end

  // Next-state and datapath updates; abort overrides everything.
  always_comb begin
    state_nxt    = state;
    gen_word_nxt = gen_word;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    mstart_nxt   = 1'b0;
    done_nxt     = done & ~done_clr;
    unique case (state)
      S_IDLE: begin
        if (start_req) begin
          if (num_points != '0) begin
            state_nxt = S_LOAD;
            done_nxt  = 1'b0;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        gen_word_nxt = start_word;
        idx_nxt      = '0;
        cnt_nxt      = settle;
        state_nxt    = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          mstart_nxt = 1'b1;
          state_nxt  = S_MEASURE;
        end else begin
          cnt_nxt = cnt - SETTLE_W'(1);
        end
      end
      S_MEASURE: begin
        // The request cycle itself cannot complete a measurement.
        if (meas_done && !meas_start) begin
          state_nxt = last_point ? S_FINISH : S_STEP;
        end
      end
      S_STEP: begin
        gen_word_nxt = gen_word + step_word;
        idx_nxt      = idx + CNT_W'(1);
        cnt_nxt      = settle;
        state_nxt    = S_SETTLE;
      end
      S_FINISH: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req && busy) begin
      state_nxt    = S_IDLE;
      gen_word_nxt = gen_word;
      idx_nxt      = idx;
      cnt_nxt      = cnt;
      mstart_nxt   = 1'b0;
      done_nxt     = done & ~done_clr;
    end
  end

  // Status word: busy, done, point index.
  always_comb begin
    status              = '0;
    status[0]           = busy;
    status[1]           = done;
    status[16 +: CNT_W] = idx;
  end

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = '0;
    case (address)
      3'd1:    readdata = start_word;
      3'd2:    readdata = step_word;
      3'd3:    readdata = DATA_W'(num_points);
      3'd4:    readdata = DATA_W'(settle);
      3'd5:    readdata = status;
      default: readdata = '0;
    endcase
  end

endmodule
